// File: rtl/aggregate_words_if.sv
// Beat-in / word-out bus of the word aggregator.
// The aggregator attaches to the slave modport; the beat source drives the master modport.
interface aggregate_words_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 32
);
  localparam int CW = $clog2(OUT_W / IN_W) + 1;

  logic              axiiv;
  logic [IN_W-1:0]   axiid;
  logic              axiov;
  logic [OUT_W-1:0]  axiod;
  logic              axiol;
  logic [CW-1:0]     axiocnt;

  modport master (
    output axiiv, axiid,
    input  axiov, axiod, axiol, axiocnt
  );

  modport slave (
    input  axiiv, axiid,
    output axiov, axiod, axiol, axiocnt
  );
endinterface

// File: rtl/aggregate_words.sv
// Packs IN_W-bit beats into OUT_W-bit words, tags the last word of a frame
// and optionally flushes a trailing partial word with its beat count.
module aggregate_words #(
  parameter int IN_W         = 2,
  parameter int OUT_W        = 32,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit EMIT_PARTIAL = 1'b1
) (
  input logic         clk,
  input logic         rst,
  aggregate_words_if.slave bus
);

  localparam int BEATS = OUT_W / IN_W;
  localparam int CW    = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT_H,
    S_EMIT_P
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [OUT_W-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_in_frame;
  logic [OUT_W-1:0] r_hold;
  logic             r_hold_v;
  logic [OUT_W-1:0] r_drain;
  logic [CW-1:0]    r_drain_cnt;
  logic             r_drain_v;

  logic             r_ov;
  logic [OUT_W-1:0] r_od;
  logic             r_ol;
  logic [CW-1:0]    r_ocnt;

  logic             w_ov_nx;
  logic [OUT_W-1:0] w_od_nx;
  logic             w_ol_nx;
  logic [CW-1:0]    w_ocnt_nx;

  logic [OUT_W-1:0] w_shift_nx;
  logic             w_beat;
  logic             w_full;
  logic             w_frame_end;
  logic             w_part_ok;
  logic             w_drain_go;

  assign w_beat      = bus.axiiv;
  assign w_full      = w_beat && (r_cnt == CW'(BEATS - 1));
  assign w_frame_end = !bus.axiiv && r_in_frame;
  assign w_part_ok   = EMIT_PARTIAL && (r_cnt != '0);
  assign w_drain_go  = (r_state == S_EMIT_H) && r_drain_v;

  // Unfilled slots stay zero, which yields the required partial justification.
  always_comb begin
    w_shift_nx = r_shift;
    for (int k = 0; k < BEATS; k++) begin
      if (r_cnt == CW'(k)) begin
        if (MSB_FIRST)
          w_shift_nx[OUT_W-(k+1)*IN_W +: IN_W] = bus.axiid;
        else
          w_shift_nx[k*IN_W +: IN_W] = bus.axiid;
      end
    end
  end

  // Drain follow-up and frame end cannot coincide: a frame end needs
  // a beat on the previous cycle, the follow-up comes right after one.
  always_comb begin
    w_state_nx = S_IDLE;
    w_ov_nx    = 1'b0;
    w_od_nx    = '0;
    w_ol_nx    = 1'b0;
    w_ocnt_nx  = '0;
    unique case (1'b1)
      w_drain_go: begin
        w_state_nx = S_EMIT_P;
        w_ov_nx    = 1'b1;
        w_od_nx    = r_drain;
        w_ol_nx    = 1'b1;
        w_ocnt_nx  = r_drain_cnt;
      end
      w_frame_end: begin
        if (r_hold_v) begin
          w_state_nx = S_EMIT_H;
          w_ov_nx    = 1'b1;
          w_od_nx    = r_hold;
          w_ol_nx    = !w_part_ok;
          w_ocnt_nx  = CW'(BEATS);
        end else if (w_part_ok) begin
          w_state_nx = S_EMIT_P;
          w_ov_nx    = 1'b1;
          w_od_nx    = r_shift;
          w_ol_nx    = 1'b1;
          w_ocnt_nx  = r_cnt;
        end
      end
      default: begin
        if (w_full && r_hold_v) begin
          w_ov_nx   = 1'b1;
          w_od_nx   = r_hold;
          w_ocnt_nx = CW'(BEATS);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_in_frame  <= 1'b0;
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
      r_drain     <= '0;
      r_drain_cnt <= '0;
      r_drain_v   <= 1'b0;
      r_ov        <= 1'b0;
      r_od        <= '0;
      r_ol        <= 1'b0;
      r_ocnt      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_ov       <= w_ov_nx;
      r_od       <= w_od_nx;
      r_ol       <= w_ol_nx;
      r_ocnt     <= w_ocnt_nx;
      r_in_frame <= bus.axiiv;
      if (w_drain_go)
        r_drain_v <= 1'b0;
      if (w_beat) begin
        if (w_full) begin
          r_shift  <= '0;
          r_cnt    <= '0;
          r_hold   <= w_shift_nx;
          r_hold_v <= 1'b1;
        end else begin
          r_shift <= w_shift_nx;
          r_cnt   <= r_cnt + 1'b1;
        end
      end else if (w_frame_end) begin
        r_drain     <= r_shift;
        r_drain_cnt <= r_cnt;
        r_drain_v   <= r_hold_v && w_part_ok;
        r_shift     <= '0;
        r_cnt       <= '0;
        r_hold_v    <= 1'b0;
      end
    end
  end

  assign bus.axiov   = r_ov;
  assign bus.axiod   = r_od;
  assign bus.axiol   = r_ol;
  assign bus.axiocnt = r_ocnt;

endmodule
